// File: rtl/reorder_buffer.sv
// ---------------------------------------------------------------------------
// reorder_buffer
//
// In-order retirement queue sitting between the decoder, the common data bus
// (CDB) and the register file. Issuing instructions receive a tag (the tail
// pointer). Results broadcast on the CDB are captured by tag. The oldest
// entry retires as soon as its result is present, driving the register
// file's commit port. A branch that retires with a wrong predicted direction
// flushes every entry and pulses out_clear_all together with the correct PC.
//
// Tag 0 is reserved as "no tag". Pointers therefore cycle through
// 1..ROB_SIZE-1, so the capacity is ROB_SIZE-1 entries.
//
// Ports
//   clk, rst                  clock; synchronous active-high reset
//   ena                       global enable; low freezes all state and idles
//                             the commit port
//   in_issue_*                decoder issue request (valid, rd, branch info)
//   out_alloc_tag, out_full   tag handed to the issuing instruction, and
//                             "no free entry" (both combinational)
//   in_cdb_*                  result broadcast (tag, value, branch outcome)
//   in_query_tag1/2           operand lookups from the decoder
//   out_query_ready1/2,
//   out_query_value1/2        combinational lookup results
//   out_commit_*              registered commit port (reg index, tag, value);
//                             reg index and tag are 0 when nothing retires
//   out_clear_all             registered one-cycle flush pulse
//   out_redirect_pc           registered correct PC, valid with out_clear_all
// ---------------------------------------------------------------------------
module reorder_buffer #(
    parameter int ROB_SIZE   = 16,
    parameter int ROB_WIDTH  = 4,
    parameter int DATA_WIDTH = 32,
    parameter int REG_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ena,

    input  logic                  in_issue_valid,
    input  logic [REG_WIDTH-1:0]  in_issue_rd,
    input  logic                  in_issue_is_branch,
    input  logic                  in_issue_pred_taken,
    output logic [ROB_WIDTH-1:0]  out_alloc_tag,
    output logic                  out_full,

    input  logic                  in_cdb_valid,
    input  logic [ROB_WIDTH-1:0]  in_cdb_tag,
    input  logic [DATA_WIDTH-1:0] in_cdb_value,
    input  logic                  in_cdb_taken,
    input  logic [DATA_WIDTH-1:0] in_cdb_target,

    input  logic [ROB_WIDTH-1:0]  in_query_tag1,
    input  logic [ROB_WIDTH-1:0]  in_query_tag2,
    output logic                  out_query_ready1,
    output logic [DATA_WIDTH-1:0] out_query_value1,
    output logic                  out_query_ready2,
    output logic [DATA_WIDTH-1:0] out_query_value2,

    output logic [REG_WIDTH-1:0]  out_commit_reg_index,
    output logic [ROB_WIDTH-1:0]  out_commit_tag,
    output logic [DATA_WIDTH-1:0] out_commit_value,
    output logic                  out_clear_all,
    output logic [DATA_WIDTH-1:0] out_redirect_pc
);

    localparam logic [ROB_WIDTH-1:0] FIRST_TAG = ROB_WIDTH'(1);
    localparam logic [ROB_WIDTH-1:0] LAST_TAG  = ROB_WIDTH'(ROB_SIZE - 1);

    // -----------------------------------------------------------------------
    // Entry storage, indexed directly by tag. Index 0 is never allocated.
    // Control bits (valid/ready) are reset; payload fields are not.
    // -----------------------------------------------------------------------
    logic [ROB_SIZE-1:0]   entry_valid;
    logic [ROB_SIZE-1:0]   entry_ready;
    logic [ROB_SIZE-1:0]   entry_is_branch;
    logic [ROB_SIZE-1:0]   entry_pred_taken;
    logic [ROB_SIZE-1:0]   entry_taken;
    logic [REG_WIDTH-1:0]  entry_rd     [ROB_SIZE];
    logic [DATA_WIDTH-1:0] entry_value  [ROB_SIZE];
    logic [DATA_WIDTH-1:0] entry_target [ROB_SIZE];

    logic [ROB_WIDTH-1:0]  head;
    logic [ROB_WIDTH-1:0]  tail;
    logic [ROB_WIDTH-1:0]  count;

    // Event strobes for the current cycle.
    logic issue_fire;
    logic cdb_fire;
    logic commit_fire;
    logic mispredict;

    // Pointer increment that skips the reserved tag 0.
    function automatic logic [ROB_WIDTH-1:0] next_ptr(input logic [ROB_WIDTH-1:0] ptr);
        return (ptr == LAST_TAG) ? FIRST_TAG : ptr + FIRST_TAG;
    endfunction

    // -----------------------------------------------------------------------
    // Allocation side
    // -----------------------------------------------------------------------
    assign out_alloc_tag = tail;
    assign out_full      = (count == LAST_TAG);

    // -----------------------------------------------------------------------
    // Event decode
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default before any branch,
        // so no path leaves a signal unassigned and no latch is inferred.
        issue_fire  = 1'b0;
        cdb_fire    = 1'b0;
        commit_fire = 1'b0;
        mispredict  = 1'b0;
        if (ena) begin
            // Issue is blocked during the flush pulse: the front end is being
            // redirected and whatever it presents belongs to the wrong path.
            issue_fire  = in_issue_valid && !out_full && !out_clear_all;
            cdb_fire    = in_cdb_valid && (in_cdb_tag != '0) && entry_valid[in_cdb_tag];
            commit_fire = entry_valid[head] && entry_ready[head];
            mispredict  = commit_fire && entry_is_branch[head] &&
                          (entry_taken[head] != entry_pred_taken[head]);
        end
    end

    // -----------------------------------------------------------------------
    // Control state: pointers, occupancy, valid/ready bits
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // right-hand side below sees the pre-edge value regardless of order.
        if (rst) begin
            head        <= FIRST_TAG;
            tail        <= FIRST_TAG;
            count       <= '0;
            entry_valid <= '0;
            entry_ready <= '0;
        end else if (mispredict) begin
            // Wrong-path flush wins over any same-cycle issue or CDB write.
            head        <= FIRST_TAG;
            tail        <= FIRST_TAG;
            count       <= '0;
            entry_valid <= '0;
            entry_ready <= '0;
        end else begin
            if (issue_fire) begin
                entry_valid[tail] <= 1'b1;
                entry_ready[tail] <= 1'b0;
                tail              <= next_ptr(tail);
            end
            if (cdb_fire) begin
                entry_ready[in_cdb_tag] <= 1'b1;
            end
            // Placed after the CDB write so a late broadcast to the retiring
            // entry cannot leave a stale ready bit behind.
            if (commit_fire) begin
                entry_valid[head] <= 1'b0;
                entry_ready[head] <= 1'b0;
                head              <= next_ptr(head);
            end
            case ({issue_fire, commit_fire})
                2'b10:   count <= count + FIRST_TAG;
                2'b01:   count <= count - FIRST_TAG;
                default: count <= count;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Payload storage
    // -----------------------------------------------------------------------
    // NOTE: the payload arrays are deliberately left out of reset; an entry's
    // fields are only ever read while its valid bit is set, and valid bits
    // are reset above, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (!mispredict) begin
            if (issue_fire) begin
                entry_rd[tail]         <= in_issue_rd;
                entry_is_branch[tail]  <= in_issue_is_branch;
                entry_pred_taken[tail] <= in_issue_pred_taken;
            end
            if (cdb_fire) begin
                entry_value[in_cdb_tag]  <= in_cdb_value;
                entry_taken[in_cdb_tag]  <= in_cdb_taken;
                entry_target[in_cdb_tag] <= in_cdb_target;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Registered commit port and flush pulse
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            out_commit_reg_index <= '0;
            out_commit_tag       <= '0;
            out_commit_value     <= '0;
            out_clear_all        <= 1'b0;
            out_redirect_pc      <= '0;
        end else begin
            out_clear_all <= mispredict;
            if (mispredict) begin
                out_redirect_pc <= entry_target[head];
            end
            if (commit_fire) begin
                out_commit_reg_index <= entry_rd[head];
                out_commit_tag       <= head;
                out_commit_value     <= entry_value[head];
            end else begin
                // Index/tag of 0 make the register file write a no-op; the
                // value is left as is to avoid needless toggling.
                out_commit_reg_index <= '0;
                out_commit_tag       <= '0;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Operand queries. Tag 0 never matches because entry 0 is never valid,
    // but it is excluded explicitly so the "no tag" meaning is obvious.
    // -----------------------------------------------------------------------
    assign out_query_ready1 = (in_query_tag1 != '0) && entry_valid[in_query_tag1] &&
                              entry_ready[in_query_tag1];
    assign out_query_ready2 = (in_query_tag2 != '0) && entry_valid[in_query_tag2] &&
                              entry_ready[in_query_tag2];
    assign out_query_value1 = out_query_ready1 ? entry_value[in_query_tag1] : '0;
    assign out_query_value2 = out_query_ready2 ? entry_value[in_query_tag2] : '0;

endmodule

// File: tb/tb_reorder_buffer.sv
// ---------------------------------------------------------------------------
// tb_reorder_buffer
//
// Directed stimulus with hand-computed expectations. Expected retirements are
// queued by the stimulus; an independent monitor pops and compares every
// time the commit port shows a retiring entry (non-zero commit tag).
// ---------------------------------------------------------------------------
module tb_reorder_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        ena;
    logic        in_issue_valid;
    logic [4:0]  in_issue_rd;
    logic        in_issue_is_branch;
    logic        in_issue_pred_taken;
    logic [3:0]  out_alloc_tag;
    logic        out_full;
    logic        in_cdb_valid;
    logic [3:0]  in_cdb_tag;
    logic [31:0] in_cdb_value;
    logic        in_cdb_taken;
    logic [31:0] in_cdb_target;
    logic [3:0]  in_query_tag1;
    logic [3:0]  in_query_tag2;
    logic        out_query_ready1;
    logic [31:0] out_query_value1;
    logic        out_query_ready2;
    logic [31:0] out_query_value2;
    logic [4:0]  out_commit_reg_index;
    logic [3:0]  out_commit_tag;
    logic [31:0] out_commit_value;
    logic        out_clear_all;
    logic [31:0] out_redirect_pc;

    always #5 clk = ~clk;

    reorder_buffer dut (
        .clk                  (clk),
        .rst                  (rst),
        .ena                  (ena),
        .in_issue_valid       (in_issue_valid),
        .in_issue_rd          (in_issue_rd),
        .in_issue_is_branch   (in_issue_is_branch),
        .in_issue_pred_taken  (in_issue_pred_taken),
        .out_alloc_tag        (out_alloc_tag),
        .out_full             (out_full),
        .in_cdb_valid         (in_cdb_valid),
        .in_cdb_tag           (in_cdb_tag),
        .in_cdb_value         (in_cdb_value),
        .in_cdb_taken         (in_cdb_taken),
        .in_cdb_target        (in_cdb_target),
        .in_query_tag1        (in_query_tag1),
        .in_query_tag2        (in_query_tag2),
        .out_query_ready1     (out_query_ready1),
        .out_query_value1     (out_query_value1),
        .out_query_ready2     (out_query_ready2),
        .out_query_value2     (out_query_value2),
        .out_commit_reg_index (out_commit_reg_index),
        .out_commit_tag       (out_commit_tag),
        .out_commit_value     (out_commit_value),
        .out_clear_all        (out_clear_all),
        .out_redirect_pc      (out_redirect_pc)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [3:0]  tag;
        logic [31:0] value;
        logic        flush;
        logic [31:0] pc;
    } commit_t;

    commit_t exp_q[$];
    int      n_checks = 0;
    int      n_pass   = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    task automatic expect_commit(input logic [4:0] rd, input logic [3:0] tag,
                                 input logic [31:0] value, input logic flush,
                                 input logic [31:0] pc);
        commit_t e;
        e.rd = rd; e.tag = tag; e.value = value; e.flush = flush; e.pc = pc;
        exp_q.push_back(e);
    endtask

    // Monitor: compare every retirement against the scoreboard.
    commit_t got;
    always @(negedge clk) begin
        if (out_commit_tag != 4'd0) begin
            if (exp_q.size() == 0) begin
                check("unexpected_commit_tag", 32'(out_commit_tag), 32'd0);
            end else begin
                got = exp_q.pop_front();
                check("commit_reg_index", 32'(out_commit_reg_index), 32'(got.rd));
                check("commit_tag",       32'(out_commit_tag),       32'(got.tag));
                check("commit_value",     out_commit_value,          got.value);
                check("commit_clear_all", 32'(out_clear_all),        32'(got.flush));
                if (got.flush) check("commit_redirect_pc", out_redirect_pc, got.pc);
            end
        end else if (out_clear_all) begin
            check("spurious_clear_all", 32'(out_clear_all), 32'd0);
        end
    end

    // All stimulus tasks start and end at 1 time unit after a rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_issue_valid = 1'b0;
        in_cdb_valid   = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic issue(input logic [4:0] rd, input logic br, input logic pt,
                         input logic [3:0] exp_tag);
        in_issue_valid      = 1'b1;
        in_issue_rd         = rd;
        in_issue_is_branch  = br;
        in_issue_pred_taken = pt;
        @(negedge clk);
        check("alloc_tag", 32'(out_alloc_tag), 32'(exp_tag));
        tick();
        in_issue_valid = 1'b0;
    endtask

    task automatic cdb(input logic [3:0] tag, input logic [31:0] value,
                       input logic taken, input logic [31:0] target);
        in_cdb_valid  = 1'b1;
        in_cdb_tag    = tag;
        in_cdb_value  = value;
        in_cdb_taken  = taken;
        in_cdb_target = target;
        tick();
        in_cdb_valid = 1'b0;
    endtask

    initial begin
        ena                 = 1'b1;
        rst                 = 1'b1;
        in_issue_valid      = 1'b0;
        in_issue_rd         = '0;
        in_issue_is_branch  = 1'b0;
        in_issue_pred_taken = 1'b0;
        in_cdb_valid        = 1'b0;
        in_cdb_tag          = '0;
        in_cdb_value        = '0;
        in_cdb_taken        = 1'b0;
        in_cdb_target       = '0;
        in_query_tag1       = '0;
        in_query_tag2       = '0;

        // ---- Reset state, then three plain issues ----
        do_reset();
        @(negedge clk);
        check("rst_alloc_tag",    32'(out_alloc_tag),        32'd1);
        check("rst_full",         32'(out_full),             32'd0);
        check("rst_commit_reg",   32'(out_commit_reg_index), 32'd0);
        check("rst_commit_tag",   32'(out_commit_tag),       32'd0);
        check("rst_commit_value", out_commit_value,          32'd0);
        check("rst_clear_all",    32'(out_clear_all),        32'd0);
        check("rst_redirect_pc",  out_redirect_pc,           32'd0);
        check("query_tag0_ready", 32'(out_query_ready1),     32'd0);
        check("query_tag0_value", out_query_value1,          32'd0);
        tick();
        issue(5'd5, 1'b0, 1'b0, 4'd1);
        issue(5'd6, 1'b0, 1'b0, 4'd2);
        issue(5'd7, 1'b0, 1'b0, 4'd3);
        in_query_tag1 = 4'd1;
        in_query_tag2 = 4'd3;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("idle_full",        32'(out_full),             32'd0);
            check("idle_commit_reg",  32'(out_commit_reg_index), 32'd0);
            check("pending_ready1",   32'(out_query_ready1),     32'd0);
            check("pending_ready2",   32'(out_query_ready2),     32'd0);
            tick();
        end

        // ---- Out-of-order results, in-order retirement ----
        expect_commit(5'd5, 4'd1, 32'h11, 1'b0, 32'd0);
        expect_commit(5'd6, 4'd2, 32'h22, 1'b0, 32'd0);
        expect_commit(5'd7, 4'd3, 32'h33, 1'b0, 32'd0);
        cdb(4'd3, 32'h33, 1'b0, 32'd0);
        cdb(4'd1, 32'h11, 1'b0, 32'd0);
        cdb(4'd2, 32'h22, 1'b0, 32'd0);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            check("commit_sequence_tag", 32'(out_commit_tag), (i == 4) ? 32'd0 : 32'(i));
            tick();
        end
        @(negedge clk);
        check("drained_alloc_tag", 32'(out_alloc_tag), 32'd4);
        check("drained_full",      32'(out_full),      32'd0);
        tick();

        // ---- Fill to capacity, reject, retire one, wrap ----
        do_reset();
        for (int i = 1; i <= 15; i++) issue(5'(i), 1'b0, 1'b0, 4'(i));
        @(negedge clk);
        check("fill_full",      32'(out_full),      32'd1);
        check("fill_alloc_tag", 32'(out_alloc_tag), 32'd1);
        tick();
        in_issue_valid = 1'b1;
        in_issue_rd    = 5'd20;
        tick();
        in_issue_valid = 1'b0;
        @(negedge clk);
        check("reject_alloc_tag", 32'(out_alloc_tag), 32'd1);
        check("reject_full",      32'(out_full),      32'd1);
        tick();
        expect_commit(5'd1, 4'd1, 32'hABCD, 1'b0, 32'd0);
        cdb(4'd1, 32'hABCD, 1'b0, 32'd0);
        in_query_tag1 = 4'd1;
        in_query_tag2 = 4'd2;
        @(negedge clk);
        check("query_ready1", 32'(out_query_ready1), 32'd1);
        check("query_value1", out_query_value1,      32'hABCD);
        check("query_ready2", 32'(out_query_ready2), 32'd0);
        check("query_value2", out_query_value2,      32'd0);
        tick();
        @(negedge clk);
        check("retire_full",      32'(out_full),      32'd0);
        check("retire_alloc_tag", 32'(out_alloc_tag), 32'd1);
        tick();
        issue(5'd9, 1'b0, 1'b0, 4'd1);
        @(negedge clk);
        check("refill_full", 32'(out_full), 32'd1);
        tick();

        // ---- Branch misprediction flush ----
        do_reset();
        issue(5'd0, 1'b1, 1'b0, 4'd1);
        issue(5'd3, 1'b0, 1'b0, 4'd2);
        issue(5'd4, 1'b0, 1'b0, 4'd3);
        cdb(4'd2, 32'h22, 1'b0, 32'd0);
        expect_commit(5'd0, 4'd1, 32'd0, 1'b1, 32'h100);
        cdb(4'd1, 32'd0, 1'b1, 32'h100);
        // Issue during the mispredicting commit cycle must be dropped.
        in_issue_valid = 1'b1;
        in_issue_rd    = 5'd8;
        tick();
        // Issue during the flush pulse must be ignored.
        in_issue_rd   = 5'd9;
        in_query_tag1 = 4'd2;
        @(negedge clk);
        check("flush_clear_all",   32'(out_clear_all),    32'd1);
        check("flush_redirect_pc", out_redirect_pc,       32'h100);
        check("flush_alloc_tag",   32'(out_alloc_tag),    32'd1);
        check("flush_full",        32'(out_full),         32'd0);
        check("flush_query_ready", 32'(out_query_ready1), 32'd0);
        tick();
        in_issue_valid = 1'b0;
        @(negedge clk);
        check("post_flush_clear_all", 32'(out_clear_all), 32'd0);
        check("post_flush_alloc_tag", 32'(out_alloc_tag), 32'd1);
        tick();
        tick();
        tick();

        // ---- Reset while entries hold results ----
        do_reset();
        for (int i = 1; i <= 5; i++) issue(5'(i), 1'b0, 1'b0, 4'(i));
        for (int t = 2; t <= 5; t++) cdb(4'(t), 32'h100 + 32'(t), 1'b0, 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        in_query_tag1 = 4'd2;
        in_query_tag2 = 4'd5;
        @(negedge clk);
        check("midrst_alloc_tag",  32'(out_alloc_tag),    32'd1);
        check("midrst_full",       32'(out_full),         32'd0);
        check("midrst_commit_tag", 32'(out_commit_tag),   32'd0);
        check("midrst_ready1",     32'(out_query_ready1), 32'd0);
        check("midrst_ready2",     32'(out_query_ready2), 32'd0);
        tick();
        tick();
        tick();

        @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
